// File: rtl/oclib_thermal_throttle.sv
// Thermal throttle governor: hysteretic threshold compare, dwell-qualified level
// stepping, and serial expansion of the level into an evenly spread clock-enable map.
module oclib_thermal_throttle #(
  parameter int ThrottleMapW = 8,
  parameter int TempW        = 10,
  parameter int DwellSamples = 4,
  parameter int MaxLevel     = ThrottleMapW - 1,
  localparam int LevelW      = $clog2(ThrottleMapW)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    enable,
  input  logic [TempW-1:0]        temperature,
  input  logic                    temperatureValid,
  input  logic [TempW-1:0]        throttleThreshold,
  input  logic [TempW-1:0]        warnThreshold,
  input  logic [TempW-1:0]        hysteresis,
  output logic [ThrottleMapW-1:0] throttleMap,
  output logic                    thermalWarning,
  output logic [LevelW-1:0]       level,
  output logic                    mapUpdated,
  output logic [1:0]              dbg_state
);

  localparam int CntW = $clog2(DwellSamples + 1);
  localparam int AccW = $clog2(2 * ThrottleMapW);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_GEN     = 2'd1,
    S_PUBLISH = 2'd2
  } state_t;

  state_t                  state_q, state_d;
  logic [CntW-1:0]         hot_cnt_q, hot_cnt_d, cool_cnt_q, cool_cnt_d;
  logic [LevelW-1:0]       level_q, level_d, gen_level_q, gen_level_d;
  logic [LevelW-1:0]       idx_q, idx_d;
  logic [AccW-1:0]         acc_q, acc_d;
  logic [ThrottleMapW-1:0] shadow_q, shadow_d, map_q, map_d;
  logic                    map_updated_q, map_updated_d;
  logic                    warn_q, warn_d;

  // Compares are one bit wider than the sample so temperature + hysteresis never wraps.
  logic [TempW:0] temp_ext, temp_hyst;
  logic           is_hot, is_cool;
  logic [CntW-1:0] hot_inc, cool_inc;
  logic [AccW-1:0] acc_sum;
  logic            acc_wrap;
  logic            level_chg;

  assign temp_ext  = {1'b0, temperature};
  assign temp_hyst = temp_ext + {1'b0, hysteresis};
  assign is_hot    = temp_ext >= {1'b0, throttleThreshold};
  assign is_cool   = temp_hyst < {1'b0, throttleThreshold};
  assign hot_inc   = hot_cnt_q + CntW'(1);
  assign cool_inc  = cool_cnt_q + CntW'(1);
  assign acc_sum   = acc_q + AccW'(gen_level_q);
  assign acc_wrap  = acc_sum >= AccW'(ThrottleMapW);

  always_comb begin
    level_d    = level_q;
    hot_cnt_d  = hot_cnt_q;
    cool_cnt_d = cool_cnt_q;
    if (!enable) begin
      hot_cnt_d  = '0;
      cool_cnt_d = '0;
      level_d    = '0;
    end else if (temperatureValid) begin
      if (is_hot) begin
        if (hot_inc == CntW'(DwellSamples)) begin
          hot_cnt_d = '0;
          if (level_q < LevelW'(MaxLevel)) level_d = level_q + LevelW'(1);
        end else begin
          hot_cnt_d = hot_inc;
        end
      end else begin
        hot_cnt_d = '0;
      end
      if (is_cool) begin
        if (cool_inc == CntW'(DwellSamples)) begin
          cool_cnt_d = '0;
          if (level_q != '0) level_d = level_q - LevelW'(1);
        end else begin
          cool_cnt_d = cool_inc;
        end
      end else begin
        cool_cnt_d = '0;
      end
    end
  end

  always_comb begin
    warn_d = warn_q;
    if (temperatureValid) begin
      if (temp_ext >= {1'b0, warnThreshold}) warn_d = 1'b1;
      else if (temp_hyst < {1'b0, warnThreshold}) warn_d = 1'b0;
    end
  end

  assign level_chg = level_d != level_q;

  // A level change in any state restarts generation; an aborted pass never publishes.
  always_comb begin
    state_d       = state_q;
    gen_level_d   = gen_level_q;
    acc_d         = acc_q;
    idx_d         = idx_q;
    shadow_d      = shadow_q;
    map_d         = map_q;
    map_updated_d = 1'b0;
    if (level_chg) begin
      state_d     = S_GEN;
      gen_level_d = level_d;
      acc_d       = '0;
      idx_d       = '0;
    end else begin
      case (state_q)
        S_GEN: begin
          acc_d           = acc_wrap ? acc_sum - AccW'(ThrottleMapW) : acc_sum;
          shadow_d[idx_q] = !acc_wrap;
          idx_d           = idx_q + LevelW'(1);
          if (idx_q == LevelW'(ThrottleMapW - 1)) state_d = S_PUBLISH;
        end
        S_PUBLISH: begin
          map_d         = shadow_q;
          map_updated_d = 1'b1;
          state_d       = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q       <= S_IDLE;
      hot_cnt_q     <= '0;
      cool_cnt_q    <= '0;
      level_q       <= '0;
      gen_level_q   <= '0;
      idx_q         <= '0;
      acc_q         <= '0;
      shadow_q      <= '1;
      map_q         <= '1;
      map_updated_q <= 1'b0;
      warn_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      hot_cnt_q     <= hot_cnt_d;
      cool_cnt_q    <= cool_cnt_d;
      level_q       <= level_d;
      gen_level_q   <= gen_level_d;
      idx_q         <= idx_d;
      acc_q         <= acc_d;
      shadow_q      <= shadow_d;
      map_q         <= map_d;
      map_updated_q <= map_updated_d;
      warn_q        <= warn_d;
    end
  end

  assign throttleMap    = map_q;
  assign thermalWarning = warn_q;
  assign level          = level_q;
  assign mapUpdated     = map_updated_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_oclib_thermal_throttle.sv
// Directed bench for oclib_thermal_throttle (W=8, TempW=10, dwell 4) with
// hand-computed expected levels, maps and pulse counts.
module tb_oclib_thermal_throttle;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic [9:0] temperature;
  logic       temperatureValid;
  logic [9:0] throttleThreshold;
  logic [9:0] warnThreshold;
  logic [9:0] hysteresis;
  logic [7:0] throttleMap;
  logic       thermalWarning;
  logic [2:0] level;
  logic       mapUpdated;
  logic [1:0] dbg_state;

  int checks = 0;
  int errors = 0;
  int pulse_cnt = 0;
  int snap;

  oclib_thermal_throttle dut (
    .clock             (clock),
    .reset             (reset),
    .enable            (enable),
    .temperature       (temperature),
    .temperatureValid  (temperatureValid),
    .throttleThreshold (throttleThreshold),
    .warnThreshold     (warnThreshold),
    .hysteresis        (hysteresis),
    .throttleMap       (throttleMap),
    .thermalWarning    (thermalWarning),
    .level             (level),
    .mapUpdated        (mapUpdated),
    .dbg_state         (dbg_state)
  );

  always #5 clock = ~clock;

  // Pulse monitor samples 2 time units after the active edge.
  always @(posedge clock) begin
    #2;
    if (mapUpdated === 1'b1) pulse_cnt++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One valid sample; returns at the negedge right after the capturing edge.
  task automatic send(input logic [9:0] t);
    temperature      = t;
    temperatureValid = 1'b1;
    @(negedge clock);
    temperatureValid = 1'b0;
  endtask

  task automatic send_n(input logic [9:0] t, input int n);
    for (int i = 0; i < n; i++) send(t);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    reset             = 1'b1;
    enable            = 1'b1;
    temperature       = '0;
    temperatureValid  = 1'b0;
    throttleThreshold = 10'd500;
    warnThreshold     = 10'd700;
    hysteresis        = 10'd20;
    tick(3);
    reset = 1'b0;
    tick(1);

    check("reset_map",   throttleMap, 32'hFF);
    check("reset_level", level, 0);
    check("reset_warn",  thermalWarning, 0);
    check("reset_pulse", mapUpdated, 0);
    check("reset_state", dbg_state, 0);

    // Single step up
    snap = pulse_cnt;
    send_n(10'd600, 3);
    check("l0_after3", level, 0);
    send(10'd600);
    check("l1_level", level, 1);
    tick(8);
    check("l1_map_hold", throttleMap, 32'hFF);
    check("l1_no_pulse_yet", mapUpdated, 0);
    tick(1);
    check("l1_map", throttleMap, 32'h7F);
    check("l1_pulse", mapUpdated, 1);
    tick(2);
    check("l1_pulse_cnt", pulse_cnt - snap, 1);

    // Multiple steps with aborted passes in between
    snap = pulse_cnt;
    send_n(10'd600, 12);
    check("l4_level", level, 4);
    tick(9);
    check("l4_map", throttleMap, 32'h55);
    tick(2);
    check("l4_pulse_cnt", pulse_cnt - snap, 1);

    // Saturation
    send_n(10'd600, 12);
    check("l7_level", level, 7);
    tick(9);
    check("l7_map", throttleMap, 32'h01);
    tick(2);
    snap = pulse_cnt;
    send_n(10'd600, 8);
    tick(12);
    check("sat_level", level, 7);
    check("sat_map", throttleMap, 32'h01);
    check("sat_no_pulse", pulse_cnt - snap, 0);

    // Cool down to level 2
    send_n(10'd400, 20);
    check("l2_level", level, 2);
    tick(9);
    check("l2_map", throttleMap, 32'h77);
    tick(2);

    // Hysteresis band
    snap = pulse_cnt;
    send_n(10'd490, 6);
    tick(10);
    check("band_level", level, 2);
    check("band_no_pulse", pulse_cnt - snap, 0);
    send(10'd479);
    send(10'd479);
    send(10'd490);
    send_n(10'd479, 3);
    check("band_reset_cool", level, 2);
    send(10'd479);
    check("band_step_down", level, 1);
    tick(9);
    check("band_map", throttleMap, 32'h7F);
    tick(2);

    // Warning flag (throttle threshold raised so samples only cool)
    throttleThreshold = 10'd1000;
    check("warn_pre", thermalWarning, 0);
    send(10'd700);
    check("warn_set", thermalWarning, 1);
    send(10'd685);
    check("warn_hold685", thermalWarning, 1);
    send(10'd680);
    check("warn_hold680", thermalWarning, 1);
    send(10'd679);
    check("warn_clear", thermalWarning, 0);
    check("warn_phase_level", level, 0);
    tick(9);
    check("warn_phase_map", throttleMap, 32'hFF);
    tick(2);

    // Abort to level 3, then drop enable
    throttleThreshold = 10'd500;
    snap = pulse_cnt;
    send_n(10'd600, 12);
    check("l3_level", level, 3);
    tick(9);
    check("l3_map", throttleMap, 32'h5B);
    tick(2);
    check("l3_pulse_cnt", pulse_cnt - snap, 1);
    enable = 1'b0;
    tick(1);
    check("dis_level", level, 0);
    tick(8);
    check("dis_map_hold", throttleMap, 32'h5B);
    tick(1);
    check("dis_map", throttleMap, 32'hFF);
    check("dis_pulse", mapUpdated, 1);
    tick(2);

    // Reset in the middle of a generation pass
    enable = 1'b1;
    send_n(10'd600, 4);
    check("rst_pre_level", level, 1);
    tick(3);
    snap = pulse_cnt;
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    check("rst_map",   throttleMap, 32'hFF);
    check("rst_level", level, 0);
    check("rst_pulse", mapUpdated, 0);
    check("rst_state", dbg_state, 0);
    tick(12);
    check("rst_no_pulse", pulse_cnt - snap, 0);
    check("rst_map_after", throttleMap, 32'hFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/oclib_thermal_throttle.md
# oclib_thermal_throttle

Closed-loop throttle governor that produces the `throttleMap` and `thermalWarning` inputs consumed by the clock-control gate. It samples a temperature stream, such as a sysmon reading, compares each sample against programmable thresholds with hysteresis, and steps a throttle level up or down after a dwell count. The level is serially expanded into an evenly distributed clock-enable bit pattern. All logic runs in the gated block's source clock domain; the consumer re-synchronises its inputs.

## Interface
- `ThrottleMapW`, default 8: width of the `throttleMap` output; must be ≥2.
- `TempW`, default 10: width of the temperature sample and threshold ports.
- `DwellSamples`, default 4: number of consecutive qualifying samples required before a level step; must be ≥1.
- `MaxLevel`, default `ThrottleMapW-1`: saturation limit for `level`; must be ≤`ThrottleMapW-1`.

Ports:
- `clock`  in  1: the only clock.
- `reset`  in  1: synchronous, active-high.
- `enable`  in  1: 0 forces the target level to 0.
- `temperature`  in  TempW: unsigned sample.
- `temperatureValid`  in  1: single-cycle qualifier for `temperature`.
- `throttleThreshold`  in  TempW: hot limit for level stepping.
- `warnThreshold`  in  TempW: limit for `thermalWarning`.
- `hysteresis`  in  TempW: cool margin below each threshold.
- `throttleMap`  out  ThrottleMapW: 1 = clock enabled in that slot.
- `thermalWarning`  out  1: hysteretic over-temperature flag.
- `level`  out  $clog2(ThrottleMapW): current throttle level (number of disabled slots).
- `mapUpdated`  out  1: one-cycle pulse when a new `throttleMap` is published.

## Operation
- **Comparisons** are evaluated only on `temperatureValid` cycles. Compare in TempW+1 bits so no underflow occurs:
  - hot = `temperature >= throttleThreshold`
  - cool = `temperature + hysteresis < throttleThreshold`
  - neither = in-band
- **Dwell counters.**
  - `hotCount` increments on a hot sample and clears on any non-hot valid sample.
  - `coolCount` is the mirror image for cool samples.
  - When a counter reaches `DwellSamples`, the level steps by one and that counter clears.
  - Stepping saturates at `MaxLevel` and at 0. A saturated step still clears the counter but does not start a map generation.
- **Enable.** `enable`=0 clears both counters. If `level`≠0, the level is forced to 0 on the next cycle and a generation starts.
- **Warning.**
  - `thermalWarning` sets on a valid sample with `temperature >= warnThreshold`.
  - It clears on a valid sample with `temperature + hysteresis < warnThreshold`.
  - Otherwise it holds. It is independent of `enable`.
- **Map-generation FSM** has states IDLE, GEN and PUBLISH.
  - IDLE → GEN on a level change. This latches `genLevel` and sets `acc`=0 and `idx`=0.
  - In GEN, each cycle computes `acc += genLevel`. If `acc >= ThrottleMapW`, then `acc -= ThrottleMapW` and `shadow[idx]`=0; otherwise `shadow[idx]`=1. `idx` increments each cycle.
  - After `idx`=ThrottleMapW-1, GEN → PUBLISH.
  - In PUBLISH, `throttleMap` ← `shadow` and `mapUpdated`=1, then → IDLE.
  - A level change while in GEN or PUBLISH restarts GEN with the new level. The old `throttleMap` holds and no pulse is issued for the aborted pass.
  - Result: level L yields exactly L zero bits, evenly spread, and bit 0 is always 1 when L<ThrottleMapW.

## Timing
- **Reset values:** `throttleMap`=all ones, `thermalWarning`=0, `level`=0, `mapUpdated`=0, FSM=IDLE, counters=0.
- **Level latency:** a qualifying sample at cycle t updates `level` at t+1.
- **Map latency:** GEN occupies t+1..t+ThrottleMapW and PUBLISH is t+ThrottleMapW+1. The new `throttleMap` and `mapUpdated` appear at t+ThrottleMapW+2, which is 10 cycles for W=8.
- **Warning latency:** `thermalWarning` updates 1 cycle after the valid sample.
- **Reset mid-generation:** aborts the pass immediately and returns all state to the reset values above.
- **Back-to-back valid samples:** supported every cycle. With `DwellSamples`=1, continuous hot samples re-trigger GEN every cycle, and publishing occurs only once the level saturates.
- **Consumer side:** the consumer may sample `throttleMap` at any cycle and never sees a partial pattern.

## Test plan
- **Reset:** assert `reset` mid-GEN → next cycle `throttleMap`=0xFF, `level`=0, no `mapUpdated`.
- **Step up, single level:** W=8, `throttleThreshold`=500, 4 valid samples of 600 → `level`=1 and, 9 cycles later, `throttleMap`=0x7F with a `mapUpdated` pulse.
- **Step up, multiple levels:** 12 more samples of 600 → `level`=4 with `throttleMap`=0x55. Continue to saturation → `level`=7, `throttleMap`=0x01, and further hot samples produce no `mapUpdated`.
- **Hysteresis band:** `hysteresis`=20, at `level`=2 (map 0x77).
  - Samples at 490 (in-band) → no change.
  - Samples 479,479,490,479,479,479,479 → single step to `level`=1 after the 7th sample, because the in-band sample cleared `coolCount`.
- **Warning flag:** `warnThreshold`=700, `hysteresis`=20.
  - Sample 700 → `thermalWarning`=1.
  - Samples 685 then 680 → stays 1.
  - Sample 679 → 0.
- **Abort and enable:** a level change during GEN restarts the pass, giving exactly one `mapUpdated` with the final level's pattern. Dropping `enable` at `level`=3 → `level`=0 next cycle and `throttleMap`=0xFF 9 cycles later.
